// File: rtl/stream_ctrl_pkg.sv
// Shared definitions for the host stream controller: parser states and command codes.
package stream_ctrl_pkg;

  typedef enum logic [2:0] {
    S_HUNT,
    S_GET_CMD,
    S_GET_LEN,
    S_DATA,
    S_CFG,
    S_SKIP
  } state_e;

  localparam logic [7:0] CMD_DATA     = 8'h01;
  localparam logic [7:0] CMD_SET_MODE = 8'h02;
  localparam logic [7:0] CMD_START    = 8'h03;
  localparam logic [7:0] CMD_STOP     = 8'h04;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/stream_ctrl.sv
// Host byte-stream framer: forwards DATA payload to the sample FIFO and sequences
// modulator start/prefill/stop, reporting framing errors and FIFO underruns.
//
// state     | meaning
// S_HUNT    | waiting for the sync byte, everything else dropped
// S_GET_CMD | next byte is the command code
// S_GET_LEN | next byte is the payload length; START/STOP execute here
// S_DATA    | payload bytes go straight to the FIFO
// S_CFG     | single SET_MODE payload byte
// S_SKIP    | discarding payload of a rejected frame
module stream_ctrl
  import stream_ctrl_pkg::*;
#(
  parameter int unsigned MODE_W         = 2,
  parameter int unsigned PREFILL        = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1280000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data_si,
  input  logic              rx_valid_si,
  output logic              rx_ready_si,
  output logic [7:0]        fifo_wr_data,
  output logic              fifo_wr_en,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  output logic              mod_enable,
  output logic [MODE_W-1:0] mode,
  output logic              running,
  output logic              frame_err,
  output logic [7:0]        underrun_cnt
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [9:0] PF_MAX  = 10'(PREFILL);
  localparam logic [9:0] PF_LAST = 10'(PREFILL - 1);

  state_e              state_q;
  logic [7:0]          cmd_q;
  logic [7:0]          rem_q;
  logic [IDLE_W-1:0]   idle_q;
  logic [9:0]          prefill_q, prefill_d;
  logic                primed_q, primed_d;
  logic                running_q, running_d;
  logic                mod_enable_q;
  logic [MODE_W-1:0]   mode_q;
  logic                frame_err_q;
  logic [7:0]          underrun_q;
  logic                empty_q;

  logic accept;
  logic start_exec;
  logic stop_exec;
  logic underrun_rise;
  logic timeout;

  assign rx_ready_si  = (state_q == S_DATA) ? !fifo_full : 1'b1;
  assign accept       = rx_valid_si & rx_ready_si;
  assign fifo_wr_en   = (state_q == S_DATA) & rx_valid_si & !fifo_full;
  assign fifo_wr_data = rx_data_si;

  assign start_exec    = accept && (state_q == S_GET_LEN) && (cmd_q == CMD_START) && (rx_data_si == 8'd0);
  assign stop_exec     = accept && (state_q == S_GET_LEN) && (cmd_q == CMD_STOP) && (rx_data_si == 8'd0);
  assign underrun_rise = fifo_empty & !empty_q & mod_enable_q;
  assign timeout       = !accept && (state_q != S_HUNT) && (idle_q == IDLE_LAST);

  // Next-state values feed mod_enable directly so it tracks the write that primes it.
  always_comb begin
    running_d = running_q;
    primed_d  = primed_q;
    prefill_d = prefill_q;
    if (start_exec) begin
      running_d = 1'b1;
      primed_d  = 1'b0;
      prefill_d = '0;
    end else if (stop_exec) begin
      running_d = 1'b0;
      primed_d  = 1'b0;
    end else if (running_q && fifo_wr_en) begin
      if (prefill_q != PF_MAX) prefill_d = prefill_q + 10'd1;
      if (prefill_q == PF_LAST) primed_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_HUNT;
      cmd_q        <= '0;
      rem_q        <= '0;
      idle_q       <= '0;
      prefill_q    <= '0;
      primed_q     <= 1'b0;
      running_q    <= 1'b0;
      mod_enable_q <= 1'b0;
      mode_q       <= '0;
      frame_err_q  <= 1'b0;
      underrun_q   <= '0;
      empty_q      <= 1'b0;
    end else begin
      frame_err_q  <= 1'b0;
      running_q    <= running_d;
      primed_q     <= primed_d;
      prefill_q    <= prefill_d;
      mod_enable_q <= running_d & primed_d;
      empty_q      <= fifo_empty;

      if (start_exec) underrun_q <= '0;
      else if (underrun_rise) underrun_q <= sat_inc8(underrun_q);

      if (accept || state_q == S_HUNT) idle_q <= '0;
      else idle_q <= idle_q + 1'b1;

      if (timeout) begin
        state_q     <= S_HUNT;
        frame_err_q <= 1'b1;
      end else if (accept) begin
        case (state_q)
          S_HUNT: if (rx_data_si == SYNC_BYTE) state_q <= S_GET_CMD;
          S_GET_CMD: begin
            cmd_q   <= rx_data_si;
            state_q <= S_GET_LEN;
          end
          S_GET_LEN: begin
            rem_q   <= rx_data_si;
            state_q <= S_HUNT;
            case (cmd_q)
              CMD_DATA: if (rx_data_si != 8'd0) state_q <= S_DATA;
              CMD_SET_MODE: begin
                if (rx_data_si == 8'd1) state_q <= S_CFG;
                else begin
                  frame_err_q <= 1'b1;
                  if (rx_data_si != 8'd0) state_q <= S_SKIP;
                end
              end
              CMD_START, CMD_STOP: begin
                if (rx_data_si != 8'd0) begin
                  frame_err_q <= 1'b1;
                  state_q     <= S_SKIP;
                end
              end
              default: begin
                frame_err_q <= 1'b1;
                if (rx_data_si != 8'd0) state_q <= S_SKIP;
              end
            endcase
          end
          S_DATA, S_SKIP: begin
            rem_q <= rem_q - 8'd1;
            if (rem_q == 8'd1) state_q <= S_HUNT;
          end
          S_CFG: begin
            // Mode is frozen while the modulator runs; a late SET_MODE is an error.
            if (!running_q) mode_q <= rx_data_si[MODE_W-1:0];
            else frame_err_q <= 1'b1;
            state_q <= S_HUNT;
          end
          default: state_q <= S_HUNT;
        endcase
      end
    end
  end

  assign mod_enable   = mod_enable_q;
  assign mode         = mode_q;
  assign running      = running_q;
  assign frame_err    = frame_err_q;
  assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_stream_ctrl.sv
// Self-checking bench for stream_ctrl: table of command frames plus hand-written
// prefill/backpressure, underrun/stop, timeout and mid-frame reset sequences.
module tb_stream_ctrl;

  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data_si;
  logic       rx_valid_si;
  logic       rx_ready_si;
  logic [7:0] fifo_wr_data;
  logic       fifo_wr_en;
  logic       fifo_full;
  logic       fifo_empty;
  logic       mod_enable;
  logic [1:0] mode;
  logic       running;
  logic       frame_err;
  logic [7:0] underrun_cnt;

  always #5 clk = ~clk;

  stream_ctrl #(
    .MODE_W(2), .PREFILL(64), .TIMEOUT_CYCLES(TO), .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data_si(rx_data_si), .rx_valid_si(rx_valid_si), .rx_ready_si(rx_ready_si),
    .fifo_wr_data(fifo_wr_data), .fifo_wr_en(fifo_wr_en),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .mod_enable(mod_enable), .mode(mode), .running(running),
    .frame_err(frame_err), .underrun_cnt(underrun_cnt)
  );

  typedef struct packed {
    logic [47:0] bytes;
    logic [3:0]  n;
    logic [1:0]  exp_mode;
    logic        exp_run;
    logic [1:0]  exp_err;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int err_pulses = 0;
  int wr_count = 0;
  bit chk_men_next = 1'b0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: every FIFO strobe is scored against the payload queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) err_pulses++;
      if (chk_men_next) begin
        check("mod_enable_cycle_after_64th_write", {31'd0, mod_enable}, 32'd1);
        chk_men_next = 1'b0;
      end
      if (fifo_wr_en) begin
        wr_count++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got data %0h with no byte pending", fifo_wr_data);
        end else begin
          check("fifo_wr_data", {24'd0, fifo_wr_data}, {24'd0, exp_q.pop_front()});
        end
        if (wr_count == 64) begin
          check("mod_enable_at_64th_write", {31'd0, mod_enable}, 32'd0);
          chk_men_next = 1'b1;
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit is_payload);
    bit done = 1'b0;
    int waited = 0;
    rx_data_si  = b;
    rx_valid_si = 1'b1;
    if (is_payload) exp_q.push_back(b);
    while (!done) begin
      @(negedge clk);
      done = rx_ready_si;
      @(posedge clk);
      #1;
      if (!done) begin
        waited++;
        if (waited > 200) begin
          n_cmp++;
          n_bad++;
          $display("FAIL send_timeout: byte %0h not accepted after %0d cycles", b, waited);
          done = 1'b1;
        end
      end
    end
    rx_valid_si = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  task automatic realign();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[10];
  int   e0;
  int   bp_bad;
  int   k_seen;
  logic [7:0] pay;

  initial begin
    vecs[0] = '{48'h55_A5_02_01_03_00, 4'd5, 2'd3, 1'b0, 2'd0};
    vecs[1] = '{48'hA5_03_01_77_00_00, 4'd4, 2'd3, 1'b0, 2'd1};
    vecs[2] = '{48'hA5_7E_02_A5_02_00, 4'd5, 2'd3, 1'b0, 2'd1};
    vecs[3] = '{48'hA5_02_01_02_00_00, 4'd4, 2'd2, 1'b0, 2'd0};
    vecs[4] = '{48'hA5_02_02_00_00_00, 4'd5, 2'd2, 1'b0, 2'd1};
    vecs[5] = '{48'hA5_03_00_00_00_00, 4'd3, 2'd2, 1'b1, 2'd0};
    vecs[6] = '{48'hA5_02_01_01_00_00, 4'd4, 2'd2, 1'b1, 2'd1};
    vecs[7] = '{48'hA5_04_00_00_00_00, 4'd3, 2'd2, 1'b0, 2'd0};
    vecs[8] = '{48'hA5_02_01_03_00_00, 4'd4, 2'd3, 1'b0, 2'd0};
    vecs[9] = '{48'hA5_03_00_00_00_00, 4'd3, 2'd3, 1'b1, 2'd0};

    rst = 1'b1;
    rx_data_si = 8'd0;
    rx_valid_si = 1'b0;
    fifo_full = 1'b0;
    fifo_empty = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rx_ready", {31'd0, rx_ready_si}, 32'd1);
    check("reset_fifo_wr_en", {31'd0, fifo_wr_en}, 32'd0);
    check("reset_mod_enable", {31'd0, mod_enable}, 32'd0);
    check("reset_mode", {30'd0, mode}, 32'd0);
    check("reset_running", {31'd0, running}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_underrun_cnt", {24'd0, underrun_cnt}, 32'd0);
    realign();
    rst = 1'b0;
    realign();

    for (int v = 0; v < 10; v++) begin
      logic [47:0] bb;
      bb = vecs[v].bytes;
      e0 = err_pulses;
      for (int i = 0; i < int'(vecs[v].n); i++) send(bb[47-8*i -: 8], 1'b0);
      settle();
      check($sformatf("vec%0d_mode", v), {30'd0, mode}, {30'd0, vecs[v].exp_mode});
      check($sformatf("vec%0d_running", v), {31'd0, running}, {31'd0, vecs[v].exp_run});
      check($sformatf("vec%0d_mod_enable", v), {31'd0, mod_enable}, 32'd0);
      check($sformatf("vec%0d_frame_err_pulses", v), 32'(err_pulses - e0), {30'd0, vecs[v].exp_err});
      realign();
    end

    // Prefill with a 10-cycle backpressure window in the middle of the payload.
    e0 = err_pulses;
    send(8'hA5, 1'b0);
    send(8'h01, 1'b0);
    send(8'h40, 1'b0);
    for (int i = 0; i < 64; i++) begin
      pay = 8'(i * 37 + 5);
      if (i == 20) begin
        fifo_full = 1'b1;
        rx_data_si = pay;
        rx_valid_si = 1'b1;
        bp_bad = 0;
        repeat (10) begin
          @(negedge clk);
          if (rx_ready_si !== 1'b0 || fifo_wr_en !== 1'b0) bp_bad++;
          @(posedge clk);
          #1;
        end
        fifo_full = 1'b0;
        check("backpressure_violations", 32'(bp_bad), 32'd0);
      end
      send(pay, 1'b1);
    end
    settle();
    check("prefill_write_count", 32'(wr_count), 32'd64);
    check("prefill_queue_drained", 32'(exp_q.size()), 32'd0);
    check("prefill_mod_enable", {31'd0, mod_enable}, 32'd1);
    check("prefill_frame_err_pulses", 32'(err_pulses - e0), 32'd0);
    realign();

    for (int k = 0; k < 3; k++) begin
      fifo_empty = 1'b1;
      repeat (2) realign();
      fifo_empty = 1'b0;
      repeat (2) realign();
    end
    @(negedge clk);
    check("underrun_cnt", {24'd0, underrun_cnt}, 32'd3);
    check("mod_enable_through_underrun", {31'd0, mod_enable}, 32'd1);
    realign();

    send(8'hA5, 1'b0);
    send(8'h04, 1'b0);
    @(negedge clk);
    check("mod_enable_before_stop", {31'd0, mod_enable}, 32'd1);
    realign();
    send(8'h00, 1'b0);
    @(negedge clk);
    check("stop_running", {31'd0, running}, 32'd0);
    check("stop_mod_enable", {31'd0, mod_enable}, 32'd0);
    realign();

    e0 = err_pulses;
    send(8'hA5, 1'b0);
    send(8'h01, 1'b0);
    send(8'h05, 1'b0);
    send(8'h3C, 1'b1);
    send(8'hC3, 1'b1);
    k_seen = 0;
    for (int k = 1; k <= 150 && k_seen == 0; k++) begin
      @(negedge clk);
      if (frame_err) k_seen = k;
    end
    check("timeout_latency", 32'(k_seen), 32'(TO + 1));
    realign();
    send(8'hA5, 1'b0);
    send(8'h03, 1'b0);
    send(8'h00, 1'b0);
    settle();
    check("after_timeout_running", {31'd0, running}, 32'd1);
    check("timeout_frame_err_pulses", 32'(err_pulses - e0), 32'd1);
    check("timeout_queue_drained", 32'(exp_q.size()), 32'd0);
    realign();

    // Reset mid-DATA: the next sync must start a fresh frame, not be written.
    send(8'hA5, 1'b0);
    send(8'h01, 1'b0);
    send(8'h05, 1'b0);
    send(8'h11, 1'b1);
    rst = 1'b1;
    repeat (2) realign();
    rst = 1'b0;
    @(negedge clk);
    check("midreset_running", {31'd0, running}, 32'd0);
    check("midreset_mode", {30'd0, mode}, 32'd0);
    realign();
    send(8'hA5, 1'b0);
    send(8'h02, 1'b0);
    send(8'h01, 1'b0);
    send(8'h01, 1'b0);
    settle();
    check("after_reset_mode", {30'd0, mode}, 32'd1);
    check("after_reset_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
